pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_block.sv | 41 ++++
 rtl/pipelined_cla_adder.sv | 177 +++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions: block width and the 4-bit group generate/propagate
// function used by every cla_block.
package cla_pkg;

  localparam int unsigned BLK_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Group G is the OR of each bit generate ANDed with all propagates above it.
  function automatic gp_t group_gp(input logic [BLK_W-1:0] g, input logic [BLK_W-1:0] p);
    gp_t r;
    logic term;
    r.p = &p;
    r.g = 1'b0;
    for (int i = 0; i < BLK_W; i++) begin
      term = g[i];
      for (int m = i + 1; m < BLK_W; m++) term = term & p[m];
      r.g = r.g | term;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One 4-bit carry-lookahead block: bit carries from lookahead, plus group G/P for the
// stage-level lookahead. G/P depend only on the operands, never on c_in.
module cla_block
  import cla_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             c_in,
  output logic [BLK_W-1:0] sum,
  output logic             G,
  output logic             P
);

  logic [BLK_W-1:0] bit_g;
  logic [BLK_W-1:0] bit_p;
  logic [BLK_W-1:0] c;
  logic             t;
  gp_t              gp;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  always_comb begin
    t = 1'b0;
    for (int j = 0; j < BLK_W; j++) begin
      c[j] = c_in;
      for (int m = 0; m < j; m++) c[j] = c[j] & bit_p[m];
      for (int i = 0; i < j; i++) begin
        t = bit_g[i];
        for (int m = i + 1; m < j; m++) t = t & bit_p[m];
        c[j] = c[j] | t;
      end
    end
  end

  assign sum = bit_p ^ c;
  assign gp  = group_gp(bit_g, bit_p);
  assign G   = gp.g;
  assign P   = gp.p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with per-stage valid/ready flow control.
// Define CLA_OVERFLOW_EN to add the signed-overflow output ovf.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK = WIDTH / BLK_W;
  localparam int unsigned BPS  = NBLK / STAGES;
  localparam int unsigned SW   = BPS * BLK_W;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] adv;
  logic              adv_chain;

  // Stall chain runs from the output back to stage 0.
  always_comb begin
    adv       = '0;
    adv_chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]    = !v_q[k] || adv_chain;
      adv_chain = adv[k];
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) v_in[k] = v_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) v_q[k] <= v_in[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO = k * SW;
    localparam int unsigned LW = LO + SW;
    localparam int unsigned RW = WIDTH - LO;

    logic [RW-1:0]  a_nx;
    logic [RW-1:0]  b_nx;
    logic           sub_s;
    logic           c_s;
    logic [SW-1:0]  a_s;
    logic [SW-1:0]  b_s;
    logic [SW-1:0]  blk_sum;
    logic [BPS-1:0] grp_g;
    logic [BPS-1:0] grp_p;
    logic [BPS:0]   bc;
    logic           t;
    logic [LW-1:0]  sum_d;
    logic [LW-1:0]  sum_q;
    logic           c_q;

    if (k == 0) begin : g_src
      assign a_nx  = a;
      assign b_nx  = b;
      assign sub_s = sub;
      assign c_s   = sub ? 1'b1 : cin;
      assign sum_d = blk_sum;
    end else begin : g_src
      assign a_nx  = g_stg[k-1].g_hi.a_q;
      assign b_nx  = g_stg[k-1].g_hi.b_q;
      assign sub_s = g_stg[k-1].g_hi.sub_q;
      assign c_s   = g_stg[k-1].c_q;
      assign sum_d = {blk_sum, g_stg[k-1].sum_q};
    end

    // b is carried raw between stages and inverted where it is consumed.
    assign a_s = a_nx[SW-1:0];
    assign b_s = b_nx[SW-1:0] ^ {SW{sub_s}};

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      cla_block u_blk (
        .a   (a_s[j*BLK_W +: BLK_W]),
        .b   (b_s[j*BLK_W +: BLK_W]),
        .c_in(bc[j]),
        .sum (blk_sum[j*BLK_W +: BLK_W]),
        .G   (grp_g[j]),
        .P   (grp_p[j])
      );
    end

    always_comb begin
      t = 1'b0;
      for (int j = 0; j <= BPS; j++) begin
        bc[j] = c_s;
        for (int m = 0; m < j; m++) bc[j] = bc[j] & grp_p[m];
        for (int i = 0; i < j; i++) begin
          t = grp_g[i];
          for (int m = i + 1; m < j; m++) t = t & grp_p[m];
          bc[j] = bc[j] | t;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv[k] && v_in[k]) begin
        sum_q <= sum_d;
        c_q   <= bc[BPS];
      end
    end

    if (k < STAGES - 1) begin : g_hi
      logic [RW-SW-1:0] a_q;
      logic [RW-SW-1:0] b_q;
      logic             sub_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (adv[k] && v_in[k]) begin
          a_q   <= a_nx[RW-1:SW];
          b_q   <= b_nx[RW-1:SW];
          sub_q <= sub_s;
        end
      end
    end

`ifdef CLA_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv[k] && v_in[k]) begin
          ovf_q <= (a_s[SW-1] ^ b_s[SW-1] ^ blk_sum[SW-1]) ^ bc[BPS];
        end
      end
    end
`endif
  end

  assign sum  = g_stg[STAGES-1].sum_q;
  assign cout = g_stg[STAGES-1].c_q;
`ifdef CLA_OVERFLOW_EN
  assign ovf  = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, STAGES=4): vector table, stall,
// random backpressure and mid-flight reset, with a scoreboard queue of expected results.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_OVERFLOW_EN
  logic        ovf;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[13];
  logic rnd_on;

  always #5 clk = ~clk;

  pipelined_cla_adder #(
    .WIDTH (16),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                 input logic vs);
    exp_t        m;
    logic [15:0] be;
    logic [16:0] r;
    be     = vs ? ~vb : vb;
    r      = {1'b0, va} + {1'b0, be} + {16'd0, (vs ? 1'b1 : vc)};
    m.sum  = r[15:0];
    m.cout = r[16];
    m.ovf  = (va[15] == be[15]) && (r[15] != va[15]);
    return m;
  endfunction

  // Scoreboard: every handshake at the output pops one expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no output", sum);
      end else begin
        mon_e = sb.pop_front();
        check("result_sum", 32'(sum), 32'(mon_e.sum));
        check("result_cout", 32'(cout), 32'(mon_e.cout));
`ifdef CLA_OVERFLOW_EN
        check("result_ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
        n_pop++;
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input logic vs, input exp_t ex);
    int   guard;
    logic acc;
    a        = va;
    b        = vb;
    cin      = vc;
    sub      = vs;
    in_valid = 1'b1;
    guard    = 0;
    acc      = 1'b0;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(ex);
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready in %0d cycles, expected acceptance", guard);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        ex;
    exp_t        ops[6];
    logic [15:0] oa[6];
    logic [15:0] ob[6];
    logic        oc[6];
    logic        os[6];
    int          lat;
    int          idx;
    int          n0;
    int          seen;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[10] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[11] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[12] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    rnd_on    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // First vector alone: measure latency from the accepting edge.
    ex = '{tbl[0].e_sum, tbl[0].e_cout, tbl[0].e_ovf};
    send(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, ex);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'd4);
    @(posedge clk);
    #1;

    for (int i = 1; i < 13; i++) begin
      ex = '{tbl[i].e_sum, tbl[i].e_cout, tbl[i].e_ovf};
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, ex);
    end
    drain();

    // Stall: six operands offered with the output blocked.
    for (int i = 0; i < 6; i++) begin
      oa[i]  = 16'($urandom);
      ob[i]  = 16'($urandom);
      oc[i]  = 1'($urandom_range(0, 1));
      os[i]  = 1'($urandom_range(0, 1));
      ops[i] = model(oa[i], ob[i], oc[i], os[i]);
    end
    out_ready = 1'b0;
    idx       = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (idx < 6);
      a   = oa[idx];
      b   = ob[idx];
      cin = oc[idx];
      sub = os[idx];
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(ops[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("stall_accepted", 32'(idx), 32'd4);
    a   = oa[idx];
    b   = ob[idx];
    cin = oc[idx];
    sub = os[idx];
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum_held", 32'(sum), 32'(ops[0].sum));
      check("stall_cout_held", 32'(cout), 32'(ops[0].cout));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    n0        = n_pop;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (idx < 6);
      a   = oa[idx % 6];
      b   = ob[idx % 6];
      cin = oc[idx % 6];
      sub = os[idx % 6];
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(ops[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("refill_accepted", 32'(idx), 32'd6);
    check("no_bubble_results", 32'(n_pop - n0), 32'd6);
    drain();

    // Random operands with random backpressure.
    rnd_on = 1'b1;
    fork
      begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, ex);
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'h4444;
    b        = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n0        = n_pop;
    seen      = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("flushed_none_emitted", 32'(seen), 32'd0);
    check("flushed_none_popped", 32'(n_pop - n0), 32'd0);

    // Pipeline still works after the flush.
    ex = '{tbl[12].e_sum, tbl[12].e_cout, tbl[12].e_ovf};
    send(tbl[12].a, tbl[12].b, tbl[12].cin, tbl[12].sub, ex);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
